// File: rtl/sub_arb_pkg.sv
// rtl/sub_arb_pkg.sv - shared constants and FSM encoding for the subtractor arbiter
package sub_arb_pkg;

    localparam int W_DEF   = 64;
    localparam int IDW_DEF = 2;
    localparam int STAT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/sub_share_arbiter_if.sv
// rtl/sub_share_arbiter_if.sv - request/response bundle between requesters and the shared subtractor
interface sub_share_arbiter_if
    import sub_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = W_DEF,
    parameter int IDW  = IDW_DEF
);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_diff;
    logic              rsp_borrow;
    logic              rsp_overflow;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_diff, rsp_borrow, rsp_overflow
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_diff, rsp_borrow, rsp_overflow
    );

endinterface

// File: rtl/bit64_subtractor.sv
// rtl/bit64_subtractor.sv - 64-bit ripple-borrow subtractor, purely combinational
module bit64_subtractor (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] diff,
    output logic        borrow
);

    logic bw;

    always_comb begin
        bw   = 1'b0;
        diff = '0;
        for (int i = 0; i < 64; i++) begin
            diff[i] = a[i] ^ b[i] ^ bw;
            bw      = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw);
        end
        borrow = bw;
    end

endmodule

// File: rtl/sub_share_arbiter.sv
// rtl/sub_share_arbiter.sv - round-robin share of one registered 64-bit subtractor; SUB_ARB_STATS_EN adds grant counters
module sub_share_arbiter
    import sub_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = W_DEF,
    parameter int IDW  = IDW_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sub_share_arbiter_if.slave     bus
`ifdef SUB_ARB_STATS_EN
    ,
    output logic [NREQ*STAT_W-1:0] stat_grants,
    input  logic                   stat_clr
`endif
);

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] id_q;
    logic           grant_vld;
    logic [W-1:0]   op_a, op_b;
    logic [W-1:0]   sub_diff;
    logic           sub_borrow;
    logic           sub_ovf;
    int             cand;

    // Search upward from rr_ptr, wrapping, for the first active requester.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!grant_vld && |(bus.req_valid & (NREQ'(1) << cand))) begin
                grant_vld = 1'b1;
                grant_idx = IDW'(cand);
            end
        end
    end

    // Gated by rst_n so no requester sees an accept while reset is held.
    assign bus.req_ready = (rst_n && state_q == ST_IDLE && grant_vld) ?
                           (NREQ'(1) << grant_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant_vld) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    bit64_subtractor u_sub (
        .a      (op_a),
        .b      (op_b),
        .diff   (sub_diff),
        .borrow (sub_borrow)
    );

    assign sub_ovf = (op_a[W-1] & ~op_b[W-1] & ~sub_diff[W-1]) |
                     (~op_a[W-1] & op_b[W-1] & sub_diff[W-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr           <= '0;
            id_q             <= '0;
            op_a             <= '0;
            op_b             <= '0;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_id       <= '0;
            bus.rsp_diff     <= '0;
            bus.rsp_borrow   <= 1'b0;
            bus.rsp_overflow <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && grant_vld) begin
                op_a   <= W'(bus.req_a >> (int'(grant_idx) * W));
                op_b   <= W'(bus.req_b >> (int'(grant_idx) * W));
                id_q   <= grant_idx;
                rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (state_q == ST_EXEC) begin
                bus.rsp_valid    <= 1'b1;
                bus.rsp_id       <= id_q;
                bus.rsp_diff     <= sub_diff;
                bus.rsp_borrow   <= sub_borrow;
                bus.rsp_overflow <= sub_ovf;
            end
            if (state_q == ST_RESP && bus.rsp_ready) bus.rsp_valid <= 1'b0;
        end
    end

`ifdef SUB_ARB_STATS_EN
    for (genvar i = 0; i < NREQ; i++) begin : g_stat
        logic [STAT_W-1:0] cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                                          cnt <= '0;
            else if (stat_clr)                                   cnt <= '0;
            else if (bus.req_valid[i] && bus.req_ready[i] && cnt != '1) cnt <= cnt + 1'b1;
        end
        assign stat_grants[i*STAT_W +: STAT_W] = cnt;
    end
`endif

endmodule

// File: tb/tb_sub_share_arbiter.sv
// tb/tb_sub_share_arbiter.sv - scoreboard bench for sub_share_arbiter; exercises SUB_ARB_STATS_EN when defined
module tb_sub_share_arbiter;
    import sub_arb_pkg::*;

    localparam int NREQ = 3;
    localparam int W    = 64;
    localparam int IDW  = 2;

    typedef struct {
        logic [IDW-1:0] id;
        logic [63:0]    diff;
        logic           borrow;
        logic           ovf;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sub_share_arbiter_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

`ifdef SUB_ARB_STATS_EN
    logic [NREQ*16-1:0] stat_grants;
    logic               stat_clr;
`endif

    sub_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave)
`ifdef SUB_ARB_STATS_EN
        ,
        .stat_grants (stat_grants),
        .stat_clr    (stat_clr)
`endif
    );

    rsp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic rsp_t mk(int id, logic [63:0] d, logic br, logic ov);
        rsp_t r;
        r.id = IDW'(id); r.diff = d; r.borrow = br; r.ovf = ov;
        return r;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(string msg);
        n_cmp++;
        n_bad++;
        $display("FAIL %s", msg);
    endtask

    // Response monitor: pops the scoreboard on every response handshake.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("ready_onehot0", 64'($onehot0(bus.req_ready)), 64'd1);
                if (bus.rsp_valid) check("ready_while_resp", 64'(bus.req_ready), 64'd0);
                if (bus.rsp_valid && bus.rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now($sformatf("unexpected_rsp: got id %0d diff %h, expected no response",
                                           bus.rsp_id, bus.rsp_diff));
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_id", 64'(bus.rsp_id), 64'(e.id));
                        check("rsp_diff", bus.rsp_diff, e.diff);
                        check("rsp_borrow", 64'(bus.rsp_borrow), 64'(e.borrow));
                        check("rsp_overflow", 64'(bus.rsp_overflow), 64'(e.ovf));
                    end
                end
            end
        end
    end

    initial begin
`ifdef SUB_ARB_STATS_EN
        repeat (300000) @(posedge clk);
`else
        repeat (5000) @(posedge clk);
`endif
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic set_req(int i, logic [63:0] a, logic [63:0] b);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
        bus.req_valid[i]    = 1'b1;
    endtask

    task automatic wait_ready(int i, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.req_ready[i]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now($sformatf("grant_timeout: req_ready=%b, expected bit %0d set", bus.req_ready, i));
    endtask

    task automatic issue(int i, logic [63:0] a, logic [63:0] b, rsp_t e);
        bit ok;
        set_req(i, a, b);
        wait_ready(i, ok);
        if (ok) exp_q.push_back(e);
        @(posedge clk); #1;
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 60 && exp_q.size() != 0; c++) @(negedge clk);
        if (exp_q.size() != 0) fail_now($sformatf("drain: %0d responses outstanding, expected 0", exp_q.size()));
        @(posedge clk); #1;
    endtask

    int          vec_id  [6] = '{0, 1, 2, 0, 1, 2};
    logic [63:0] vec_a   [6] = '{64'd10, 64'd0, 64'h8000_0000_0000_0000, 64'd3,
                                 64'h7FFF_FFFF_FFFF_FFFF, 64'd5};
    logic [63:0] vec_b   [6] = '{64'd3, 64'd1, 64'd1, 64'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5};
    logic [63:0] vec_d   [6] = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                                 64'hFFFF_FFFF_FFFF_FFF9, 64'h8000_0000_0000_0000, 64'd0};
    logic        vec_br  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        vec_ov  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int          rr_order[6] = '{0, 1, 2, 0, 1, 2};
    logic [63:0] rr_diff [3] = '{64'd99, 64'd198, 64'd297};

    initial begin
        bit ok;
        int idx;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
`ifdef SUB_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        check("rst_rsp_diff", bus.rsp_diff, 64'd0);
        check("rst_rsp_borrow", 64'(bus.rsp_borrow), 64'd0);
        check("rst_rsp_overflow", 64'(bus.rsp_overflow), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Single request with latency: accept in N, rsp_valid from N+2.
        set_req(0, vec_a[0], vec_b[0]);
        @(negedge clk);
        check("single_req_ready", 64'(bus.req_ready), 64'b001);
        exp_q.push_back(mk(0, vec_d[0], vec_br[0], vec_ov[0]));
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        @(negedge clk);
        check("latency_n1_valid", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        check("latency_n2_valid", 64'(bus.rsp_valid), 64'd1);
        drain();

        for (int v = 1; v < 6; v++) begin
            issue(vec_id[v], vec_a[v], vec_b[v], mk(vec_id[v], vec_d[v], vec_br[v], vec_ov[v]));
            drain();
        end

        // All requesters held valid: grants must rotate 0,1,2,0,1,2.
        set_req(0, 64'd100, 64'd1);
        set_req(1, 64'd200, 64'd2);
        set_req(2, 64'd300, 64'd3);
        for (int g = 0; g < 6; g++) begin
            ok = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (bus.req_ready != '0) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                fail_now($sformatf("rr_timeout: req_ready=%b, expected a grant", bus.req_ready));
                break;
            end
            idx = 0;
            for (int k = 0; k < NREQ; k++) if (bus.req_ready[k]) idx = k;
            check("rr_grant", 64'(idx), 64'(rr_order[g]));
            exp_q.push_back(mk(idx, rr_diff[idx], 1'b0, 1'b0));
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        drain();

        // Backpressure with a competing request waiting.
        bus.rsp_ready = 1'b0;
        issue(1, 64'd50, 64'd8, mk(1, 64'd42, 1'b0, 1'b0));
        set_req(0, 64'd9, 64'd4);
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("bp_rsp_timeout: rsp_valid=0, expected 1");
        for (int h = 0; h < 5; h++) begin
            if (h != 0) @(negedge clk);
            check("bp_valid", 64'(bus.rsp_valid), 64'd1);
            check("bp_id", 64'(bus.rsp_id), 64'd1);
            check("bp_diff", bus.rsp_diff, 64'd42);
            check("bp_borrow", 64'(bus.rsp_borrow), 64'd0);
            check("bp_overflow", 64'(bus.rsp_overflow), 64'd0);
            check("bp_no_ready", 64'(bus.req_ready), 64'd0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_no_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        check("bp_next_grant", 64'(bus.req_ready), 64'b001);
        exp_q.push_back(mk(0, 64'd5, 1'b0, 1'b0));
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        drain();

        // Reset while EXEC: in-flight result dropped, first grant afterwards to 0.
        set_req(2, 64'd1, 64'd1);
        wait_ready(2, ok);
        @(posedge clk); #1;
        set_req(0, 64'd100, 64'd1);
        set_req(1, 64'd200, 64'd2);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_mid_req_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        check("rst_first_grant", 64'(bus.req_ready), 64'b001);
        exp_q.push_back(mk(0, 64'd99, 1'b0, 1'b0));
        @(posedge clk); #1;
        bus.req_valid = '0;
        drain();

`ifdef SUB_ARB_STATS_EN
        begin
            int cnt = 0;
            set_req(1, 64'd1, 64'd1);
            for (int c = 0; c < 250000 && cnt < 65600; c++) begin
                @(negedge clk);
                if (bus.req_ready[1]) begin
                    cnt++;
                    exp_q.push_back(mk(1, 64'd0, 1'b0, 1'b0));
                end
            end
            @(posedge clk); #1;
            bus.req_valid = '0;
            drain();
            check("stat_r1_saturated", 64'(stat_grants[31:16]), 64'hFFFF);
            check("stat_r0", 64'(stat_grants[15:0]), 64'd1);
            check("stat_r2", 64'(stat_grants[47:32]), 64'd0);
            stat_clr = 1'b1;
            @(posedge clk); #1;
            stat_clr = 1'b0;
            check("stat_cleared", 64'(stat_grants), 64'd0);
        end
`endif

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sub_share_arbiter.md
Name: sub_share_arbiter

Overview:
- Shares one 64-bit ripple-borrow subtractor datapath between NREQ requesters, for example the ALU, the branch comparator and the address-check unit.
- Round-robin arbitration; valid/ready handshake on each request port and on the single response port.
- Operands and results are registered, so the long ripple chain sits alone between two flop stages.
- Sits between the issue logic and the bit64_subtractor instance in the sequential core.

Parameters:
- NREQ, 2, number of requesters; legal range 2..4.
- W, 64, operand width; fixed to 64 to match the subtractor.
- IDW, 2, width of the requester ID; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*W  packed minuends; requester i uses [i*W +: W].
- req_b  in  NREQ*W  packed subtrahends, packed the same way.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_diff  out  W  a - b, modulo 2**64.
- rsp_borrow  out  1  unsigned borrow out (a < b unsigned).
- rsp_overflow  out  1  signed overflow of a - b.

Behaviour:
- Reset (async assert, sync deassert by the caller): state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_diff=0, rsp_borrow=0, rsp_overflow=0. Reset asserted mid-operation drops the in-flight operation silently.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant g is the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NREQ.
  - req_ready[g]=1 combinationally in the same cycle.
  - At the clock edge: capture op_a and op_b from requester g, set id=g, set rr_ptr=(g+1) mod NREQ, go to EXEC.
  - If no req_valid is high, stay in IDLE; req_ready=0.
- EXEC: the subtractor works on the captured operands. At the edge, register diff, borrow and overflow, set rsp_valid=1, go to RESP. req_ready=0.
- RESP:
  - Outputs are held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready=1: rsp_valid drops at the edge and the state returns to IDLE.
  - rsp_id, rsp_diff, rsp_borrow and rsp_overflow keep their last values after that.
- Latency: request accepted in cycle N, rsp_valid high from cycle N+2. Best-case throughput is one operation per 3 cycles; no overlap.
- req_ready is only ever high in IDLE and never for more than one requester.
- A requester must hold req_valid, req_a and req_b until it sees req_ready. The block does not check this.
- Fairness: a requester that stays asserted is granted within NREQ grants.
- rr_ptr wraps from NREQ-1 to 0.
- Arithmetic:
  - borrow is the ripple borrow out of bit 63.
  - overflow = (a63 & ~b63 & ~d63) | (~a63 & b63 & d63).
- Simultaneous request and rsp_ready in RESP: the request waits until IDLE, one cycle later.

Optional Feature:
- Macro SUB_ARB_STATS_EN.
- When defined:
  - Adds output port stat_grants, width NREQ*16: one saturating 16-bit grant counter per requester.
  - A counter increments on each handshake (req_valid & req_ready) of its requester and holds at 16'hFFFF.
  - Adds input stat_clr, width 1: synchronous clear of all counters, with priority over increment.
  - Counters reset to 0.
- When undefined: neither port exists, no counter logic is built, and all other behaviour is identical.

Decomposition:
- Package sub_arb_pkg holds:
  - the state encoding constants ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2;
  - the W and IDW defaults;
  - the counter width STAT_W=16.
- Exactly one sub-module: the existing bit64_subtractor, instantiated once and fed from the op_a/op_b registers.
- The round-robin grant function stays inline.

Test Plan:
- Single request: NREQ=2; req_valid=01, a=10, b=3 -> req_ready=01 in cycle 0; rsp_valid in cycle 2 with diff=7, borrow=0, overflow=0, id=0.
- Borrow and overflow cases:
  - a=0, b=1 -> diff=64'hFFFF_FFFF_FFFF_FFFF, borrow=1, overflow=0.
  - a=64'h8000_0000_0000_0000, b=1 -> diff=64'h7FFF_FFFF_FFFF_FFFF, overflow=1, borrow=0.
- Round-robin: all 3 requesters (NREQ=3) held valid for 6 grants -> grant order 0,1,2,0,1,2; at most one req_ready bit high per cycle.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and all result fields stable, no req_ready asserted. rsp_ready=1 -> next grant exactly one cycle after return to IDLE.
- Reset mid-operation: assert rst_n=0 in EXEC (async, between edges) -> rsp_valid=0 and req_ready=0 immediately. After release, the first grant goes to requester 0.
- With SUB_ARB_STATS_EN defined: 70000 grants to requester 1 -> stat_grants[31:16]=16'hFFFF. Pulsing stat_clr -> all counters 0 on the next cycle.
